mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined unsigned multiplier, the same kind of DSP resource as the four-multiplier adder tree, among NUM_REQ requesters. Each requester supplies an operand pair over a valid/ready handshake. The block grants one requester per cycle and issues the pair into a LATENCY-deep multiply pipeline. It returns the product on a shared response port, tagged with the requester index. Its purpose is to cut DSP count when several low-rate clients each need an occasional product.

---
 rtl/mult_share_arbiter.sv | 73 +++++++
 tb/tb_mult_share_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one LATENCY-deep unsigned multiplier; req_valid/req_ready/req_a/req_b in, rsp_valid/rsp_ready/rsp_data/rsp_id out, idle when nothing in flight
module mult_share_arbiter #(
  parameter int INPUT_WIDTH = 14,
  parameter int OUTPUT_WIDTH = 28,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]     req_b,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [OUTPUT_WIDTH-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic                               idle
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW = OUTPUT_WIDTH > 2*INPUT_WIDTH ? OUTPUT_WIDTH : 2*INPUT_WIDTH;
  logic adv, any, go;
  logic [ID_W-1:0] ptr, g;
  logic [ID_W:0] s;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0] prod;
  logic [LATENCY-1:0] sv;
  logic [ID_W-1:0] sid [LATENCY];
  logic [OUTPUT_WIDTH-1:0] sd [LATENCY];
  assign adv = !rsp_valid || rsp_ready;
  assign go = any && adv && !reset;
  assign req_ready = go ? grant : '0;
  assign prod = PW'(req_a[g*INPUT_WIDTH +: INPUT_WIDTH]) * PW'(req_b[g*INPUT_WIDTH +: INPUT_WIDTH]);
  assign rsp_valid = sv[LATENCY-1];
  assign rsp_data = sd[LATENCY-1];
  assign rsp_id = sid[LATENCY-1];
  assign idle = ~|sv;
  always_comb begin
    grant = '0;
    g = '0;
    any = 1'b0;
    s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      s = s >= (ID_W+1)'(NUM_REQ) ? s - (ID_W+1)'(NUM_REQ) : s;
      if (!any && req_valid[s[ID_W-1:0]]) begin
        grant[s[ID_W-1:0]] = 1'b1;
        g = s[ID_W-1:0];
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      sv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        sid[i] <= '0;
        sd[i] <= '0;
      end
    end else if (adv) begin
      if (go) ptr <= g == ID_W'(NUM_REQ-1) ? '0 : g + ID_W'(1);
      sv[0] <= go;
      sid[0] <= g;
      sd[0] <= prod[OUTPUT_WIDTH-1:0];
      for (int i = 1; i < LATENCY; i++) begin
        sv[i] <= sv[i-1];
        sid[i] <= sid[i-1];
        sd[i] <= sd[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid;
  logic [3:0] req_ready, req_ready20;
  logic [55:0] req_a, req_b;
  logic rsp_valid, rsp_valid20, rsp_ready;
  logic [27:0] rsp_data;
  logic [19:0] rsp_data20;
  logic [1:0] rsp_id, rsp_id20;
  logic idle, idle20;
  int total = 0;
  int passed = 0;
  logic [27:0] full;
  logic [19:0] low20;
  always #5 clk = ~clk;
  mult_share_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .idle(idle)
  );
  mult_share_arbiter #(.OUTPUT_WIDTH(20)) dut20 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready20),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid20), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data20), .rsp_id(rsp_id20), .idle(idle20)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic set_op(input int i, input int a, input int b);
    req_a[i*14 +: 14] = 14'(a);
    req_b[i*14 +: 14] = 14'(b);
  endtask
  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    req_valid = 4'b0000;
    tick();
    reset = 1'b0;
  endtask
  int exp_d [4] = '{10, 40, 90, 160};
  int bp_d [9] = '{0, 0, 6, 6, 6, 6, 9, 12, 15};
  logic [3:0] bp_r [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
  int wrap_id [4] = '{1, 3, 1, 3};
  initial begin
    reset = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    #1;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_idle", idle, 1);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    tick();
    reset = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 100, 200);
    #1;
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    check("single_not_yet", rsp_valid, 0);
    tick();
    #1;
    check("single_valid", rsp_valid, 1);
    check("single_data", rsp_data, 20000);
    check("single_id", rsp_id, 2);
    tick();
    #1;
    check("single_idle", idle, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10 * (i + 1));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      req_valid = k < 5 ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) check($sformatf("rr_ready%0d", k), req_ready, 32'(1) << (k % 4));
      if (k >= 2 && k <= 6) begin
        check($sformatf("rr_valid%0d", k), rsp_valid, 1);
        check($sformatf("rr_id%0d", k), rsp_id, (k - 2) % 4);
        check($sformatf("rr_data%0d", k), rsp_data, exp_d[(k - 2) % 4]);
      end
      if (k == 7) check("rr_drained", rsp_valid, 0);
    end
    tick();
    req_valid = 4'b0001;
    set_op(0, 16383, 16383);
    #1;
    check("max_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    full = 28'd16383 * 28'd16383;
    low20 = full[19:0];
    check("max_valid", rsp_valid, 1);
    check("max_data", rsp_data, 268402689);
    check("max_data20", rsp_data20, low20);
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      req_valid = k < 7 ? 4'b0010 : 4'b0000;
      rsp_ready = !(k >= 2 && k <= 4);
      if (k <= 1) set_op(1, k + 2, 3);
      if (k == 2) set_op(1, 4, 3);
      if (k == 6) set_op(1, 5, 3);
      #1;
      if (k < 7) check($sformatf("bp_ready%0d", k), req_ready, bp_r[k]);
      if (k >= 2 && k <= 8) begin
        check($sformatf("bp_valid%0d", k), rsp_valid, 1);
        check($sformatf("bp_data%0d", k), rsp_data, bp_d[k]);
        check($sformatf("bp_id%0d", k), rsp_id, 1);
      end
      if (k == 9) check("bp_idle", idle, 1);
    end
    tick();
    req_valid = 4'b0100;
    #1;
    check("rst_mid_g2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0010;
    #1;
    check("rst_mid_g1", req_ready, 4'b0010);
    tick();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("rst_mid_inflight", idle, 0);
    check("rst_mid_ready", req_ready, 4'b0000);
    tick();
    reset = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_idle", idle, 1);
    check("rst_mid_data", rsp_data, 0);
    check("rst_mid_ptr0", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    check("rst_mid_resp_id", rsp_id, 1);
    check("rst_mid_resp_valid", rsp_valid, 1);
    pulse_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      req_valid = k < 4 ? 4'b1010 : 4'b0000;
      #1;
      if (k < 4) check($sformatf("wrap_ready%0d", k), req_ready, k % 2 == 0 ? 4'b0010 : 4'b1000);
      if (k >= 2 && k <= 5) check($sformatf("wrap_id%0d", k), rsp_id, wrap_id[k - 2]);
      if (k == 6) check("wrap_idle", idle, 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
